// File: rtl/alu_result_stage_pkg.sv
// rtl/alu_result_stage_pkg.sv - shared state encoding, flag positions and opcode codes
package alu_result_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;

  function automatic logic is_arith(input logic [2:0] sel);
    return (sel == SEL_ADD) || (sel == SEL_SUB);
  endfunction

endpackage

// File: rtl/alu_result_stage_flag_gen.sv
// rtl/alu_result_stage_flag_gen.sv - combinational {N,Z,C,V} flag generation
module alu_flag_gen
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] result,
  input  logic [2:0]       sel,
  input  logic             carry,
  input  logic             ovf,
  output logic [3:0]       flags
);

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    // Carry and overflow only carry meaning for adder operations.
    if (is_arith(sel)) begin
      flags[FLAG_C] = carry;
      flags[FLAG_V] = ovf;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - two-entry skid buffer capturing ALU result, opcode tag and flags
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [2:0]       in_sel,
  input  logic             in_carry,
  input  logic             in_ovf,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_sel,
  output logic [3:0]       out_flags
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] ent_result [2];
  logic [2:0]       ent_sel    [2];
  logic [3:0]       ent_flags  [2];
  logic             head;
  logic             tail;
  logic [3:0]       in_flags;
  logic             push;
  logic             pop;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .result (in_result),
    .sel    (in_sel),
    .carry  (in_carry),
    .ovf    (in_ovf),
    .flags  (in_flags)
  );

  // Handshake decoded from registered state only, so in_ready never depends on out_ready.
  assign in_ready  = (state == EMPTY) || (state == ONE);
  assign out_valid = (state == ONE) || (state == FULL);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_result = ent_result[head];
  assign out_sel    = ent_sel[head];
  assign out_flags  = ent_flags[head];

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (pop && !push) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
    if (flush) state_next = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= EMPTY;
      head          <= 1'b0;
      tail          <= 1'b0;
      ent_result[0] <= '0;
      ent_result[1] <= '0;
      ent_sel[0]    <= '0;
      ent_sel[1]    <= '0;
      ent_flags[0]  <= '0;
      ent_flags[1]  <= '0;
    end else begin
      state <= state_next;
      if (flush) begin
        head <= 1'b0;
        tail <= 1'b0;
      end else begin
        if (push) begin
          ent_result[tail] <= in_result;
          ent_sel[tail]    <= in_sel;
          ent_flags[tail]  <= in_flags;
          tail             <= ~tail;
        end
        if (pop) head <= ~head;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed self-checking bench for alu_result_stage
module tb_alu_result_stage;

  typedef struct {
    logic [31:0] r;
    logic [2:0]  s;
    logic [3:0]  f;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [2:0]  in_sel;
  logic        in_carry;
  logic        in_ovf;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_sel;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;
  ent_t q[$];

  alu_result_stage #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_sel     (in_sel),
    .in_carry   (in_carry),
    .in_ovf     (in_ovf),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_sel    (out_sel),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Flags as the adder/ALU contract defines them: add=0, sub=1 keep C/V.
  function automatic logic [3:0] model_flags(input logic [31:0] r, input logic [2:0] s,
                                             input logic c, input logic v);
    logic arith;
    arith = (s == 3'd0) || (s == 3'd1);
    return {r[31], r == 32'd0, arith & c, arith & v};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] r, input logic [2:0] s, input logic c, input logic v);
    in_valid  = 1'b1;
    in_result = r;
    in_sel    = s;
    in_carry  = c;
    in_ovf    = v;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_result = '0;
    in_sel    = '0;
    in_carry  = 1'b0;
    in_ovf    = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    rst_n = 1'b1;
    step();

    // Pop request on an empty stage is ignored.
    out_ready = 1'b1;
    step();
    check("empty_pop_valid", 32'(out_valid), 32'd0);
    check("empty_pop_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // Zero result from add with carry: Z and C set, visible next cycle.
    drive(32'h0000_0000, 3'd0, 1'b1, 1'b0);
    step();
    idle();
    check("zero_valid", 32'(out_valid), 32'd1);
    check("zero_result", out_result, 32'h0000_0000);
    check("zero_flags", 32'(out_flags), 32'b0110);
    check("zero_sel", 32'(out_sel), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("zero_drain", 32'(out_valid), 32'd0);

    // Fill while stalled; second entry uses a non-arith code with C/V raised.
    drive(32'h8000_0001, 3'd1, 1'b0, 1'b1);
    step();
    drive(32'h0000_0005, 3'd2, 1'b1, 1'b1);
    step();
    idle();
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_head_result", out_result, 32'h8000_0001);
    check("full_head_flags", 32'(out_flags), 32'b1001);
    check("full_head_sel", 32'(out_sel), 32'd1);
    out_ready = 1'b1;
    step();
    check("second_result", out_result, 32'h0000_0005);
    check("second_flags_cv_masked", 32'(out_flags), 32'b0000);
    check("second_sel", 32'(out_sel), 32'd2);
    check("second_in_ready", 32'(in_ready), 32'd1);
    step();
    out_ready = 1'b0;
    check("order_drain", 32'(out_valid), 32'd0);

    // Back-to-back traffic holding occupancy at ONE.
    begin
      ent_t e;
      e.r = 32'hCAFE_0001; e.s = 3'd0; e.f = model_flags(e.r, e.s, 1'b1, 1'b1);
      drive(e.r, e.s, 1'b1, 1'b1);
      q.push_back(e);
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
        logic c;
        logic v;
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        check("b2b_result", out_result, q[0].r);
        check("b2b_sel", 32'(out_sel), 32'(q[0].s));
        check("b2b_flags", 32'(out_flags), 32'(q[0].f));
        e.r = (i % 10 == 3) ? 32'd0 : $urandom;
        e.s = 3'($urandom_range(0, 7));
        c   = 1'($urandom_range(0, 1));
        v   = 1'($urandom_range(0, 1));
        e.f = model_flags(e.r, e.s, c, v);
        drive(e.r, e.s, c, v);
        step();
        void'(q.pop_front());
        q.push_back(e);
      end
      idle();
      check("b2b_last_result", out_result, q[0].r);
      step();
      void'(q.pop_front());
      out_ready = 1'b0;
      check("b2b_drain", 32'(out_valid), 32'd0);
    end

    // Flush from FULL with a simultaneous push: everything discarded.
    drive(32'h0000_00A1, 3'd3, 1'b0, 1'b0);
    step();
    drive(32'h0000_00A2, 3'd4, 1'b0, 1'b0);
    step();
    check("pre_flush_ready", 32'(in_ready), 32'd0);
    drive(32'hDEAD_BEEF, 3'd0, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    drive(32'h0000_0077, 3'd5, 1'b0, 1'b0);
    step();
    idle();
    check("post_flush_result", out_result, 32'h0000_0077);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_flush_drain", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-cycle from FULL.
    drive(32'h0000_0011, 3'd0, 1'b0, 1'b0);
    step();
    drive(32'h0000_0022, 3'd0, 1'b0, 1'b0);
    step();
    idle();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd1);
    check("async_rst_result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h1234_5678, 3'd0, 1'b0, 1'b0);
    step();
    idle();
    check("after_rst_valid", 32'(out_valid), 32'd1);
    check("after_rst_result", out_result, 32'h1234_5678);
    check("after_rst_flags", 32'(out_flags), 32'b0000);
    check("after_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("after_rst_alone", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
